// File: rtl/sram_ctrl.sv
// Single-request initiator for the asynchronous-strobe SRAM: sequences cs/addr/din
// around a wr/rd strobe of STROBE_CYCLES cycles and returns a one-cycle response.
module sram_ctrl #(
    parameter int AW            = 8,
    parameter int DW            = 8,
    parameter int STROBE_CYCLES = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          resp_valid,
    output logic [DW-1:0] resp_rdata,
    output logic          sram_cs,
    output logic          sram_wr,
    output logic          sram_rd,
    output logic [AW-1:0] sram_addr,
    output logic [DW-1:0] sram_din,
    input  logic [DW-1:0] sram_dout
);

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

    localparam logic [3:0] CNT_LOAD = 4'(STROBE_CYCLES - 1);

    state_t        state_q, state_d;
    logic          we_q, we_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          ready_q, ready_d;
    logic          resp_valid_q, resp_valid_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          cs_q, cs_d;
    logic          wr_q, wr_d;
    logic          rd_q, rd_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] din_q, din_d;

    // Every output is the registered image of the state it belongs to, so the
    // next-state logic also computes the next value of each pin.
    always_comb begin
        state_d      = state_q;
        we_d         = we_q;
        cnt_d        = cnt_q;
        ready_d      = ready_q;
        resp_valid_d = 1'b0;
        rdata_d      = rdata_q;
        cs_d         = cs_q;
        wr_d         = wr_q;
        rd_d         = rd_q;
        addr_d       = addr_q;
        din_d        = din_q;
        case (state_q)
            IDLE: begin
                if (req_valid && ready_q) begin
                    state_d = SETUP;
                    we_d    = req_we;
                    addr_d  = req_addr;
                    din_d   = req_wdata;
                    cs_d    = 1'b1;
                    ready_d = 1'b0;
                end
            end
            SETUP: begin
                state_d = STROBE;
                cnt_d   = CNT_LOAD;
                wr_d    = we_q;
                rd_d    = !we_q;
            end
            STROBE: begin
                if (cnt_q == 4'd0) begin
                    state_d      = HOLD;
                    wr_d         = 1'b0;
                    rd_d         = 1'b0;
                    resp_valid_d = 1'b1;
                    if (!we_q) begin
                        rdata_d = sram_dout;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            HOLD: begin
                state_d = IDLE;
                cs_d    = 1'b0;
                ready_d = 1'b1;
            end
            default: begin
                state_d = IDLE;
                cs_d    = 1'b0;
                wr_d    = 1'b0;
                rd_d    = 1'b0;
                ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            we_q         <= 1'b0;
            cnt_q        <= 4'd0;
            ready_q      <= 1'b1;
            resp_valid_q <= 1'b0;
            rdata_q      <= '0;
            cs_q         <= 1'b0;
            wr_q         <= 1'b0;
            rd_q         <= 1'b0;
            addr_q       <= '0;
            din_q        <= '0;
        end else begin
            state_q      <= state_d;
            we_q         <= we_d;
            cnt_q        <= cnt_d;
            ready_q      <= ready_d;
            resp_valid_q <= resp_valid_d;
            rdata_q      <= rdata_d;
            cs_q         <= cs_d;
            wr_q         <= wr_d;
            rd_q         <= rd_d;
            addr_q       <= addr_d;
            din_q        <= din_d;
        end
    end

    assign req_ready  = ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = rdata_q;
    assign sram_cs    = cs_q;
    assign sram_wr    = wr_q;
    assign sram_rd    = rd_q;
    assign sram_addr  = addr_q;
    assign sram_din   = din_q;

endmodule

// File: tb/tb_sram_ctrl.sv
// Directed bench for sram_ctrl: S=2 main instance against a behavioural SRAM,
// plus S=1 and S=15 instances for strobe width and busy time.
module tb_sram_ctrl;

    localparam int S = 2;

    logic       clk;
    logic       rst_n;
    logic       req_valid, req_ready, req_we;
    logic [7:0] req_addr, req_wdata;
    logic       resp_valid;
    logic [7:0] resp_rdata;
    logic       sram_cs, sram_wr, sram_rd;
    logic [7:0] sram_addr, sram_din, sram_dout;

    logic       req_valid_1, req_ready_1, resp_valid_1, cs_1, wr_1, rd_1;
    logic [7:0] rdata_1, addr_1, din_1;
    logic       req_valid_15, req_ready_15, resp_valid_15, cs_15, wr_15, rd_15;
    logic [7:0] rdata_15, addr_15, din_15;
    logic [7:0] zero_dout;

    int errors = 0;
    int checks = 0;

    logic [7:0] mem [256];

    sram_ctrl #(.AW(8), .DW(8), .STROBE_CYCLES(S)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .sram_cs(sram_cs), .sram_wr(sram_wr), .sram_rd(sram_rd),
        .sram_addr(sram_addr), .sram_din(sram_din), .sram_dout(sram_dout)
    );

    sram_ctrl #(.AW(8), .DW(8), .STROBE_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid_1), .req_ready(req_ready_1), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid_1), .resp_rdata(rdata_1),
        .sram_cs(cs_1), .sram_wr(wr_1), .sram_rd(rd_1),
        .sram_addr(addr_1), .sram_din(din_1), .sram_dout(zero_dout)
    );

    sram_ctrl #(.AW(8), .DW(8), .STROBE_CYCLES(15)) dut15 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid_15), .req_ready(req_ready_15), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid_15), .resp_rdata(rdata_15),
        .sram_cs(cs_15), .sram_wr(wr_15), .sram_rd(rd_15),
        .sram_addr(addr_15), .sram_din(din_15), .sram_dout(zero_dout)
    );

    // Behavioural SRAM: write on the clock while cs&wr, combinational read.
    always @(posedge clk) begin
        if (sram_cs && sram_wr) mem[sram_addr] <= sram_din;
    end
    assign sram_dout = mem[sram_addr];
    assign zero_dout = 8'h00;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Presents one request at the current negedge, then checks every cycle of the
    // transaction against the fixed SETUP/STROBE/HOLD waveform.
    task automatic txn(input logic we, input logic [7:0] addr, input logic [7:0] wdata,
                       input logic [7:0] exp_rdata, input string tag);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        @(negedge clk);
        req_valid = 1'b0;
        for (int c = 1; c <= S + 2; c++) begin
            chk({tag, " cs"},    sram_cs, 1'b1);
            chk({tag, " wr"},    sram_wr, we && c >= 2 && c <= S + 1);
            chk({tag, " rd"},    sram_rd, !we && c >= 2 && c <= S + 1);
            chk({tag, " addr"},  sram_addr, addr);
            chk({tag, " din"},   sram_din, we ? wdata : sram_din);
            chk({tag, " ready"}, req_ready, 1'b0);
            chk({tag, " resp_valid"}, resp_valid, c == S + 2);
            if (c == S + 2) chk({tag, " rdata"}, resp_rdata, exp_rdata);
            @(negedge clk);
        end
        chk({tag, " ready_back"}, req_ready, 1'b1);
        chk({tag, " cs_off"},     sram_cs, 1'b0);
        chk({tag, " resp_off"},   resp_valid, 1'b0);
        $display("txn %s we=%0d addr=%02h wdata=%02h rdata=%02h", tag, we, addr, wdata, resp_rdata);
    endtask

    initial begin
        int busy1, busy15, str1, str15, waited;
        req_valid    = 1'b0;
        req_valid_1  = 1'b0;
        req_valid_15 = 1'b0;
        req_we       = 1'b0;
        req_addr     = 8'h00;
        req_wdata    = 8'h00;
        rst_n        = 1'b0;

        // Reset with random inputs presented
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            req_valid = 1'($urandom);
            req_we    = 1'($urandom);
            req_addr  = 8'($urandom);
            req_wdata = 8'($urandom);
        end
        @(negedge clk);
        chk("rst cs", sram_cs, 1'b0);
        chk("rst wr", sram_wr, 1'b0);
        chk("rst rd", sram_rd, 1'b0);
        chk("rst addr", sram_addr, 8'h00);
        chk("rst din", sram_din, 8'h00);
        chk("rst resp_valid", resp_valid, 1'b0);
        chk("rst rdata", resp_rdata, 8'h00);
        chk("rst ready", req_ready, 1'b1);
        req_valid = 1'b0;
        rst_n     = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_rst cs", sram_cs, 1'b0);
            chk("post_rst resp", resp_valid, 1'b0);
        end
        $display("reset done");

        txn(1'b1, 8'h03, 8'hB5, 8'h00, "wr03");
        txn(1'b0, 8'h03, 8'h00, 8'hB5, "rd03");
        txn(1'b1, 8'h02, 8'h11, 8'hB5, "wr02");
        txn(1'b0, 8'h02, 8'h00, 8'h11, "rd02");
        txn(1'b1, 8'h05, 8'h77, 8'h11, "wr05_keep");

        // Held request with inputs changing while busy
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 8'h20;
        req_wdata = 8'h44;
        @(negedge clk);
        for (int c = 1; c <= S + 3; c++) begin
            if (c <= S + 2) begin
                chk("held addr", sram_addr, 8'h20);
                chk("held din", sram_din, 8'h44);
                chk("held ready", req_ready, 1'b0);
            end else begin
                chk("held ready_back", req_ready, 1'b1);
                chk("held cs_off", sram_cs, 1'b0);
            end
            req_addr  = 8'h30 + 8'(c);
            req_wdata = 8'h60 + 8'(c);
            @(negedge clk);
        end
        chk("held2 cs", sram_cs, 1'b1);
        chk("held2 addr", sram_addr, 8'h35);
        chk("held2 din", sram_din, 8'h65);
        chk("held2 ready", req_ready, 1'b0);
        req_valid = 1'b0;
        waited = 0;
        while (!req_ready && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        chk("held2 done", req_ready, 1'b1);
        $display("held request second accept at cycle %0d", S + 3);

        // Reset during the write strobe
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 8'h09;
        req_wdata = 8'h5A;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        chk("midrst wr_before", sram_wr, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("midrst wr", sram_wr, 1'b0);
        chk("midrst cs", sram_cs, 1'b0);
        chk("midrst ready", req_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("midrst no_resp", resp_valid, 1'b0);
            chk("midrst idle", req_ready, 1'b1);
        end
        $display("mid-strobe reset done");
        txn(1'b0, 8'h03, 8'h00, 8'hB5, "rd03_after_rst");

        // Strobe width and busy time for S=1 and S=15
        req_we       = 1'b1;
        req_addr     = 8'h40;
        req_wdata    = 8'hC3;
        req_valid_1  = 1'b1;
        req_valid_15 = 1'b1;
        @(negedge clk);
        req_valid_1  = 1'b0;
        req_valid_15 = 1'b0;
        busy1 = 0; busy15 = 0; str1 = 0; str15 = 0;
        for (int i = 0; i < 30; i++) begin
            if (!req_ready_1)  busy1++;
            if (!req_ready_15) busy15++;
            if (wr_1)  str1++;
            if (wr_15) str15++;
            @(negedge clk);
        end
        chk("s1 strobe", 32'(str1), 32'd1);
        chk("s1 busy", 32'(busy1), 32'd3);
        chk("s15 strobe", 32'(str15), 32'd15);
        chk("s15 busy", 32'(busy15), 32'd17);
        $display("S=1 strobe=%0d busy=%0d  S=15 strobe=%0d busy=%0d", str1, busy1, str15, busy15);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
